phy_rx_deserializer: RTL



---
 rtl/phy_rx_deserializer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/phy_rx_deserializer.sv
// Serial-to-byte receiver: finds byte alignment on repeated idle commas, then emits MSB-first bytes
// tagged with a round-robin lane slot. Optional status counter enabled by macro PHY_RX_STATUS_EN.
module phy_rx_deserializer #(
  parameter logic [7:0]  COMMA      = 8'hBC,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic [1:0] lane_out,
  output logic       byte_strobe,
  output logic       active
`ifdef PHY_RX_STATUS_EN
  ,
  output logic [7:0] idle_cnt
`endif
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_RUN = 4'(LOCK_COUNT);

  state_t     state;
  state_t     state_n;
  logic [6:0] sr;
  logic [7:0] sr_next;
  logic [2:0] bit_cnt;
  logic [2:0] bit_cnt_n;
  logic [3:0] comma_run;
  logic [3:0] comma_run_n;
  logic [1:0] lane_cnt;
  logic [1:0] lane_cnt_n;
  logic       is_comma;
  logic       take_byte;

  // sr_next is the byte window ending with the bit sampled on this edge.
  assign sr_next  = {sr, data_in};
  assign is_comma = (sr_next == COMMA);
  assign active   = (state == ACTIVE);

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt + 3'd1;
    comma_run_n = comma_run;
    lane_cnt_n  = lane_cnt;
    take_byte   = 1'b0;
    case (state)
      SEARCH: begin
        bit_cnt_n = '0;
        if (is_comma) begin
          comma_run_n = 4'd1;
          lane_cnt_n  = '0;
          state_n     = (LOCK_RUN == 4'd1) ? ACTIVE : VERIFY;
        end
      end
      VERIFY: begin
        if (bit_cnt == 3'd7) begin
          if (is_comma) begin
            comma_run_n = comma_run + 4'd1;
            if (comma_run_n == LOCK_RUN) begin
              state_n    = ACTIVE;
              lane_cnt_n = '0;
            end
          end else begin
            // Aligned window broke the run: fall back to a bitwise sliding search.
            comma_run_n = '0;
            state_n     = SEARCH;
          end
        end
      end
      ACTIVE: begin
        if (bit_cnt == 3'd7) begin
          take_byte  = 1'b1;
          lane_cnt_n = lane_cnt + 2'd1;
        end
      end
      default: state_n = SEARCH;
    endcase
  end

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state <= SEARCH;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      sr          <= '0;
      bit_cnt     <= '0;
      comma_run   <= '0;
      lane_cnt    <= '0;
      data_out    <= '0;
      valid_out   <= 1'b0;
      lane_out    <= '0;
      byte_strobe <= 1'b0;
    end else begin
      sr          <= sr_next[6:0];
      bit_cnt     <= bit_cnt_n;
      comma_run   <= comma_run_n;
      lane_cnt    <= lane_cnt_n;
      byte_strobe <= take_byte;
      if (take_byte) begin
        data_out  <= sr_next;
        valid_out <= !is_comma;
        lane_out  <= lane_cnt;
      end
    end
  end

`ifdef PHY_RX_STATUS_EN
  // Counts idle strobes one cycle after they are presented; saturates at 8'hFF.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if (byte_strobe && !valid_out && (idle_cnt != 8'hFF)) begin
      idle_cnt <= idle_cnt + 8'd1;
    end
  end
`endif

endmodule
